// File: rtl/gbox_lock_ctrl.sv
// gbox_lock_ctrl: restarts the header-seeker tree, qualifies its result over frames, and holds/supervises the lock.
module gbox_lock_ctrl #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 8,
  parameter int TIMEOUT    = 1023,
  parameter int RST_CYC    = 4,
  parameter int MAX_POS    = 65
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       buffer_dv,
  input  logic       seek_synced_i,
  input  logic [6:0] seek_pos_i,
  input  logic       header_ok_i,
  output logic       seek_rst_o,
  output logic       locked_o,
  output logic [6:0] lock_pos_o,
  output logic [1:0] state_o,
  output logic [7:0] relock_cnt_o
);
  typedef enum logic [1:0] {RESET_SEEK = 2'd0, SEARCH = 2'd1, CONFIRM = 2'd2, LOCKED = 2'd3} state_t;
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [CW-1:0] LC_LIM = CW'(LOCK_CNT);
  localparam logic [BW-1:0] UL_LIM = BW'(UNLOCK_CNT);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);
  localparam logic [RW-1:0] RC_END = RW'(RST_CYC - 1);
  state_t state, state_n;
  logic [6:0] cand_pos, cand_pos_n, lock_pos_n;
  logic [CW-1:0] conf_cnt, conf_cnt_n, conf_inc;
  logic [BW-1:0] bad_cnt, bad_cnt_n, bad_inc;
  logic [TW-1:0] to_cnt, to_cnt_n, to_inc;
  logic [RW-1:0] rst_cnt, rst_cnt_n;
  logic [7:0] relock_n;
  logic seek_rst_n, locked_n, qual, same, acq, bad_frame;
  // a position beyond MAX_POS is an artefact of the seeker, never a real sync
  assign qual      = buffer_dv & seek_synced_i & (seek_pos_i <= 7'(MAX_POS));
  assign same      = seek_pos_i == cand_pos;
  assign acq       = buffer_dv & ((state == SEARCH) | (state == CONFIRM));
  assign bad_frame = buffer_dv & ~header_ok_i & (state == LOCKED);
  assign conf_inc  = conf_cnt + CW'(1);
  assign bad_inc   = bad_cnt + BW'(1);
  assign to_inc    = to_cnt + TW'(1);
  assign state_o   = state;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= RESET_SEEK;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      RESET_SEEK: state_n = (rst_cnt == RC_END) ? SEARCH : RESET_SEEK;
      SEARCH:     state_n = !buffer_dv ? SEARCH
                          : qual ? ((LOCK_CNT == 1) ? LOCKED : CONFIRM)
                          : (to_inc == TO_LIM) ? RESET_SEEK : SEARCH;
      CONFIRM:    state_n = !buffer_dv ? CONFIRM
                          : !qual ? SEARCH
                          : (same && conf_inc == LC_LIM) ? LOCKED : CONFIRM;
      LOCKED:     state_n = (bad_frame && bad_inc == UL_LIM) ? RESET_SEEK : LOCKED;
      default:    state_n = RESET_SEEK;
    endcase
  end
  always_comb begin
    rst_cnt_n  = (state == RESET_SEEK) ? rst_cnt + RW'(1) : '0;
    to_cnt_n   = (state != SEARCH) ? '0 : (buffer_dv & ~qual) ? to_inc : to_cnt;
    conf_cnt_n = (state == RESET_SEEK) ? '0
               : (acq & qual) ? (((state == CONFIRM) & same) ? conf_inc : CW'(1)) : conf_cnt;
    cand_pos_n = (acq & qual & ~((state == CONFIRM) & same)) ? seek_pos_i : cand_pos;
    bad_cnt_n  = (state == RESET_SEEK) ? '0
               : (buffer_dv & (state == LOCKED)) ? (header_ok_i ? '0 : bad_inc) : bad_cnt;
    lock_pos_n = (state_n == LOCKED && state != LOCKED) ? ((state == SEARCH) ? seek_pos_i : cand_pos) : lock_pos_o;
    relock_n   = (state == LOCKED && state_n == RESET_SEEK && relock_cnt_o != 8'hFF) ? relock_cnt_o + 8'd1 : relock_cnt_o;
    seek_rst_n = state_n == RESET_SEEK;
    locked_n   = state_n == LOCKED;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rst_cnt      <= '0;
      to_cnt       <= '0;
      conf_cnt     <= '0;
      bad_cnt      <= '0;
      cand_pos     <= '0;
      lock_pos_o   <= '0;
      relock_cnt_o <= '0;
      seek_rst_o   <= 1'b1;
      locked_o     <= 1'b0;
    end else begin
      rst_cnt      <= rst_cnt_n;
      to_cnt       <= to_cnt_n;
      conf_cnt     <= conf_cnt_n;
      bad_cnt      <= bad_cnt_n;
      cand_pos     <= cand_pos_n;
      lock_pos_o   <= lock_pos_n;
      relock_cnt_o <= relock_n;
      seek_rst_o   <= seek_rst_n;
      locked_o     <= locked_n;
    end
  end
endmodule
